// File: rtl/tone_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_meter_pkg: shared state encoding, default levels, threshold fn  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tone_meter_pkg;

  typedef enum logic [1:0] {
    ARM_LOW   = 2'd0,
    ARM_HIGH  = 2'd1,
    HIGH_HALF = 2'd2,
    LOW_HALF  = 2'd3
  } state_e;

  localparam logic [15:0] c_MID_DEFAULT  = 16'h8000;
  localparam logic [15:0] c_HYST_DEFAULT = 16'h0400;

  // Bit 16 of a 17-bit sum/difference flags overflow/borrow; clamp to the rail.
  function automatic logic [15:0] sat_th(input logic [16:0] v, input logic is_sub);
    if (v[16]) sat_th = is_sub ? 16'h0000 : 16'hFFFF;
    else       sat_th = v[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_meter_zc_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zc_detect: hysteresis comparator, above/below the band around MID    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module zc_detect
  import tone_meter_pkg::*;
#(
  parameter logic [15:0] MID  = c_MID_DEFAULT,
  parameter logic [15:0] HYST = c_HYST_DEFAULT
) (
  input  logic [15:0] sample_i,
  output logic        above_o,
  output logic        below_o
);

  logic [15:0] w_hi_th;
  logic [15:0] w_lo_th;

  assign w_hi_th = sat_th({1'b0, MID} + {1'b0, HYST}, 1'b0);
  assign w_lo_th = sat_th({1'b0, MID} - {1'b0, HYST}, 1'b1);

  assign above_o = (sample_i > w_hi_th);
  assign below_o = (sample_i < w_lo_th);

endmodule
`default_nettype wire

// File: rtl/tone_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_meter: period / peak-to-peak meter on rising hysteretic crossings|
// | Optional 4-measurement averaging: define TONE_METER_AVG_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter int             PW         = 16,
  parameter logic [15:0]    MID        = c_MID_DEFAULT,
  parameter logic [15:0]    HYST       = c_HYST_DEFAULT,
  parameter logic [PW-1:0]  MAX_PERIOD = {PW{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   sample_in,
  input  logic          sample_stb,
  output logic [PW-1:0] period,
  output logic [15:0]   amplitude,
  output logic          meas_valid,
  output logic          tone_present
);

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [15:0]   max_q, max_d, min_q, min_d;
  logic [PW-1:0] period_q, period_d;
  logic [15:0]   amp_q, amp_d;
  logic          valid_q, valid_d, tone_q, tone_d;

  logic          w_above, w_below;
  logic [PW:0]   w_cnt_inc;
  logic          w_counting, w_to_take, w_cross_take;
  logic [15:0]   w_amp_cur, w_max_upd, w_min_upd;
  logic          w_rep_fire;
  logic [PW-1:0] w_rep_period;
  logic [15:0]   w_rep_amp;

  zc_detect #(.MID(MID), .HYST(HYST)) u_zc (
    .sample_i (sample_in),
    .above_o  (w_above),
    .below_o  (w_below)
  );

  assign w_cnt_inc    = {1'b0, cnt_q} + {{PW{1'b0}}, 1'b1};
  assign w_counting   = (state_q == HIGH_HALF) || (state_q == LOW_HALF);
  // Timeout wins over a crossing arriving on the same strobe.
  assign w_to_take    = sample_stb && w_counting && (w_cnt_inc >= {1'b0, MAX_PERIOD});
  assign w_cross_take = sample_stb && (state_q == LOW_HALF) && w_above && !w_to_take;
  assign w_amp_cur    = max_q - min_q;
  assign w_max_upd    = (sample_in > max_q) ? sample_in : max_q;
  assign w_min_upd    = (sample_in < min_q) ? sample_in : min_q;

`ifdef TONE_METER_AVG_EN
  logic [PW+1:0] acc_p_q, acc_p_d, w_sum_p;
  logic [17:0]   acc_a_q, acc_a_d, w_sum_a;
  logic [1:0]    nacc_q, nacc_d;

  assign w_sum_p      = acc_p_q + {2'b00, cnt_q};
  assign w_sum_a      = acc_a_q + {2'b00, w_amp_cur};
  assign w_rep_fire   = (nacc_q == 2'd3);
  assign w_rep_period = w_sum_p[PW+1:2];
  assign w_rep_amp    = w_sum_a[17:2];

  always_comb begin
    acc_p_d = acc_p_q;
    acc_a_d = acc_a_q;
    nacc_d  = nacc_q;
    if (w_to_take || (w_cross_take && w_rep_fire)) begin
      acc_p_d = '0;
      acc_a_d = '0;
      nacc_d  = 2'd0;
    end else if (w_cross_take) begin
      acc_p_d = w_sum_p;
      acc_a_d = w_sum_a;
      nacc_d  = nacc_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p_q <= '0;
      acc_a_q <= '0;
      nacc_q  <= 2'd0;
    end else begin
      acc_p_q <= acc_p_d;
      acc_a_q <= acc_a_d;
      nacc_q  <= nacc_d;
    end
  end
`else
  assign w_rep_fire   = 1'b1;
  assign w_rep_period = cnt_q;
  assign w_rep_amp    = w_amp_cur;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    min_d    = min_q;
    period_d = period_q;
    amp_d    = amp_q;
    valid_d  = 1'b0;
    tone_d   = tone_q;
    if (w_to_take) begin
      state_d  = ARM_LOW;
      cnt_d    = '0;
      max_d    = 16'h0000;
      min_d    = 16'hFFFF;
      period_d = '0;
      amp_d    = 16'h0000;
      valid_d  = 1'b1;
      tone_d   = 1'b0;
    end else if (w_cross_take) begin
      // The crossing sample opens the new period; it is not part of the report.
      state_d = HIGH_HALF;
      cnt_d   = {{(PW-1){1'b0}}, 1'b1};
      max_d   = sample_in;
      min_d   = sample_in;
      tone_d  = 1'b1;
      if (w_rep_fire) begin
        period_d = w_rep_period;
        amp_d    = w_rep_amp;
        valid_d  = 1'b1;
      end
    end else if (sample_stb) begin
      case (state_q)
        ARM_LOW: begin
          if (w_below) state_d = ARM_HIGH;
        end
        ARM_HIGH: begin
          if (w_above) begin
            state_d = HIGH_HALF;
            cnt_d   = {{(PW-1){1'b0}}, 1'b1};
            max_d   = sample_in;
            min_d   = sample_in;
          end
        end
        default: begin
          cnt_d = (&cnt_q) ? cnt_q : w_cnt_inc[PW-1:0];
          max_d = w_max_upd;
          min_d = w_min_upd;
          if ((state_q == HIGH_HALF) && w_below) state_d = LOW_HALF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARM_LOW;
      cnt_q    <= '0;
      max_q    <= 16'h0000;
      min_q    <= 16'hFFFF;
      period_q <= '0;
      amp_q    <= 16'h0000;
      valid_q  <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      period_q <= period_d;
      amp_q    <= amp_d;
      valid_q  <= valid_d;
      tone_q   <= tone_d;
    end
  end

  assign period       = period_q;
  assign amplitude    = amp_q;
  assign meas_valid   = valid_q;
  assign tone_present = tone_q;

endmodule
`default_nettype wire

// File: doc/tone_meter.md
Name: tone_meter

Overview:
Sample-stream consumer that measures tone period and peak-to-peak amplitude from a strobed 16-bit PCM stream.
- Input stream: DDS sine generator output, or a sound-chip mixer tap.
- Detects rising zero crossings with hysteresis and counts samples between them.
- Reports the measured period, amplitude and tone-present status for testbench self-checking and on-chip level/pitch monitoring.

Parameters:
PW, 16, width of period counter and period output (samples).
MID, 16'h8000, zero level of the offset-binary input.
HYST, 16'h0400, hysteresis half-width around MID.
MAX_PERIOD, 16'hFFFF, sample count without a crossing after which the tone is declared lost; must be ≤ 2^PW-1.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sample_in  in  16  offset-binary PCM sample; valid only when sample_stb=1.
sample_stb  in  1  one-clk qualifier; any rate up to every clk.
period  out  PW  samples between the last two rising crossings.
amplitude  out  16  max-min over that same period.
meas_valid  out  1  one-clk pulse when period/amplitude update.
tone_present  out  1  level; 1 while crossings arrive within MAX_PERIOD.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high (reset).
- Reset values: period=0, amplitude=0, meas_valid=0, tone_present=0, state=ARM_LOW, cnt=0, max=0, min=16'hFFFF.
- Thresholds:
  - hi_th = MID+HYST and lo_th = MID-HYST, computed in 17 bits and saturated to 16'hFFFF and 0.
  - above = sample_in > hi_th; below = sample_in < lo_th.
- Processing happens only on clk edges with sample_stb=1; otherwise all state holds.
- States:
  - ARM_LOW: wait for below → ARM_HIGH.
  - ARM_HIGH: wait for above → first rising crossing. Go to LOW_HALF is not taken; instead go to HIGH_HALF with cnt=1, max=min=sample. No report.
  - HIGH_HALF: wait for below → LOW_HALF.
  - LOW_HALF: on above (rising crossing), in the same clk:
    - period<=cnt, amplitude<=max-min, meas_valid<=1, tone_present<=1.
    - cnt<=1, max=min=current sample.
    - Next state HIGH_HALF.
- Counting: in HIGH_HALF and LOW_HALF, every strobe does cnt<=cnt+1 and updates max/min with the current sample.
- Crossing sample: the crossing sample belongs to the new period only; it is not included in the reported amplitude.
- Latency: outputs valid on the clk after the crossing sample's strobe edge.
- Timeout: if a strobe would make cnt reach MAX_PERIOD in HIGH_HALF or LOW_HALF:
  - tone_present<=0, meas_valid<=1, period<=0, amplitude<=0.
  - state<=ARM_LOW; cnt, max and min are re-initialised.
- Timeout takes precedence over a crossing on the same strobe.
- Counters saturate and never wrap.
- Samples inside the hysteresis band never change state.
- Reset mid-measurement discards the partial period and causes no meas_valid pulse.

Optional Feature:
Macro TONE_METER_AVG_EN.
- Defined:
  - period and amplitude are averages of the last 4 completed measurements, using (PW+2)-bit and 18-bit sums with >>2 truncation.
  - meas_valid fires only every 4th crossing.
  - The accumulator clears on timeout and on reset.
- Undefined: per-period reporting as above, with no accumulator logic.

Decomposition:
- Package tone_meter_pkg:
  - state enum {ARM_LOW, ARM_HIGH, HIGH_HALF, LOW_HALF};
  - default MID/HYST constants;
  - 17-bit threshold saturating helper function.
- Sub-module zc_detect:
  - hysteresis comparator producing above/below from sample_in, MID and HYST;
  - purely combinational, instantiated once.
- Top level holds the FSM, counter, min/max and output registers.

Test Plan:
- Square wave, 50 samples 16'hC000 then 50 samples 16'h4000, strobe every 3 clk:
  - first meas_valid after the second rising edge;
  - period=100, amplitude=16'h8000, tone_present=1.
- Sine, DDS fcw=24'h004000 (1024-sample period, amplitude 16'h7FFF about MID) → period=1024 ±1, amplitude ≥16'hFFF0 on every report.
- Signal toggling 16'h8200/16'h7E00, inside HYST → no meas_valid; tone_present stays 0.
- Tone locked, then sample_in held at 16'hC000 → after MAX_PERIOD strobes: one meas_valid with period=0, amplitude=0, tone_present=0.
- Reset asserted mid-period → outputs return to reset values, no pulse; the next valid tone needs two rising crossings before reporting.
- With TONE_METER_AVG_EN, periods 100,100,102,102 → single meas_valid with period=101.
